// File: rtl/keyflow_pkg.sv
// Shared definitions for the KeyFlow route encoder: FSM encoding,
// port-to-residue mapping and error-cause codes.
package keyflow_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MOD_X  = 3'd1;
    localparam logic [2:0] ST_MOD_M  = 3'd2;
    localparam logic [2:0] ST_SEARCH = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;
    localparam logic [2:0] ST_OUT    = 3'd6;

    localparam logic [2:0] KF_RES_MAC0 = 3'd1;
    localparam logic [2:0] KF_RES_MAC1 = 3'd2;
    localparam logic [2:0] KF_RES_MAC2 = 3'd3;
    localparam logic [2:0] KF_RES_MAC3 = 3'd4;
    localparam logic [2:0] KF_RES_CPU0 = 3'd5;

    localparam logic [2:0] KF_ERR_NONE    = 3'd0;
    localparam logic [2:0] KF_ERR_PORT    = 3'd1;
    localparam logic [2:0] KF_ERR_KEY     = 3'd2;
    localparam logic [2:0] KF_ERR_RES     = 3'd3;
    localparam logic [2:0] KF_ERR_HOPS    = 3'd4;
    localparam logic [2:0] KF_ERR_COPRIME = 3'd5;
    localparam logic [2:0] KF_ERR_OVF     = 3'd6;

    function automatic logic [2:0] kf_port_res(input logic [2:0] port);
        logic [2:0] res;
        case (port)
            3'd0:    res = KF_RES_MAC0;
            3'd1:    res = KF_RES_MAC1;
            3'd2:    res = KF_RES_MAC2;
            3'd3:    res = KF_RES_MAC3;
            3'd4:    res = KF_RES_CPU0;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keyflow_mod_seq.sv
// Sequential restoring remainder: dividend mod divisor, one dividend
// bit per cycle, done asserted ROUTE_WIDTH cycles after start.
module keyflow_mod_seq
    import keyflow_pkg::*;
#(
    parameter int DIVIDER_WIDTH = 16,
    parameter int ROUTE_WIDTH   = 64
) (
    input  logic                     asclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROUTE_WIDTH-1:0]   dividend,
    input  logic [DIVIDER_WIDTH-1:0] divisor,
    output logic                     done,
    output logic [DIVIDER_WIDTH-1:0] remainder
);

    localparam int DW = DIVIDER_WIDTH;
    localparam int RW = ROUTE_WIDTH;
    localparam int CW = $clog2(RW + 1);

    logic [RW-1:0] sh;
    logic [DW-1:0] rem;
    logic [CW-1:0] cnt;
    logic          busy;

    function automatic logic [DW-1:0] step(
        input logic [DW-1:0] r,
        input logic          b,
        input logic [DW-1:0] d
    );
        logic [DW:0] tr;
        tr = {r, b};
        if (tr >= {1'b0, d})
            tr = tr - {1'b0, d};
        return tr[DW-1:0];
    endfunction

    // The start cycle already consumes the top dividend bit.
    always_ff @(posedge asclk) begin
        if (reset) begin
            sh   <= '0;
            rem  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= step('0, dividend[RW-1], divisor);
                sh   <= dividend << 1;
                cnt  <= CW'(RW - 1);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= step(rem, sh[RW-1], divisor);
                sh  <= sh << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign remainder = rem;

endmodule

// File: rtl/keyflow_route_encoder.sv
// KeyFlow route-ID encoder: folds (key, port) hops into one label by
// incremental CRT so that label mod key equals the port residue.
module keyflow_route_encoder
    import keyflow_pkg::*;
#(
    parameter int DIVIDER_WIDTH = 16,
    parameter int ROUTE_WIDTH   = 64,
    parameter int MAX_HOPS      = 8
) (
    input  logic                     asclk,
    input  logic                     reset,
    input  logic                     s_hop_valid,
    output logic                     s_hop_ready,
    input  logic [DIVIDER_WIDTH-1:0] s_hop_key,
    input  logic [2:0]               s_hop_port,
    input  logic                     s_hop_last,
    output logic                     m_route_valid,
    input  logic                     m_route_ready,
    output logic [ROUTE_WIDTH-1:0]   m_route_id,
    output logic                     m_route_err,
    output logic [3:0]               m_route_hops
);

    localparam int DW = DIVIDER_WIDTH;
    localparam int RW = ROUTE_WIDTH;
    localparam int PW = RW + DW;
    localparam logic [3:0] HOP_LIM = 4'(MAX_HOPS);

    logic [2:0]    state;
    logic [RW-1:0] x;
    logic [RW-1:0] m;
    logic [DW-1:0] k;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] t;
    logic [2:0]    r;
    logic          last;
    logic [PW-1:0] cand;
    logic [3:0]    hop_cnt;
    logic [2:0]    cause;
    logic          mod_go;

    logic          accept;
    logic [3:0]    hop_inc;
    logic [2:0]    hc;
    logic [DW:0]   sum;
    logic [DW-1:0] sum_red;
    logic [PW-1:0] prod;
    logic          mod_done;
    logic [DW-1:0] mod_rem;
    logic [RW-1:0] mod_dividend;

    function automatic logic [2:0] hop_cause(
        input logic [2:0]    port,
        input logic [DW-1:0] key,
        input logic [3:0]    cnt
    );
        logic [2:0] c;
        c = KF_ERR_NONE;
        if (port > 3'd4)
            c = KF_ERR_PORT;
        else if (key < DW'(2))
            c = KF_ERR_KEY;
        else if (DW'(kf_port_res(port)) >= key)
            c = KF_ERR_RES;
        else if (cnt >= HOP_LIM)
            c = KF_ERR_HOPS;
        return c;
    endfunction

    assign s_hop_ready = !reset &&
                         (state == ST_IDLE || state == ST_DRAIN);
    assign accept  = s_hop_valid && s_hop_ready;
    assign hop_inc = (hop_cnt == 4'hf) ? hop_cnt : hop_cnt + 4'd1;
    assign hc      = hop_cause(s_hop_port, s_hop_key, hop_cnt);

    // a and b are residues below k, so one conditional subtract suffices.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign sum_red = (sum >= {1'b0, k}) ? DW'(sum - {1'b0, k})
                                        : sum[DW-1:0];
    assign prod    = PW'(m) * PW'(k);

    assign mod_dividend = (state == ST_MOD_M) ? m : x;

    keyflow_mod_seq #(
        .DIVIDER_WIDTH(DW),
        .ROUTE_WIDTH  (RW)
    ) u_mod (
        .asclk    (asclk),
        .reset    (reset),
        .start    (mod_go),
        .dividend (mod_dividend),
        .divisor  (k),
        .done     (mod_done),
        .remainder(mod_rem)
    );

    always_ff @(posedge asclk) begin
        if (reset) begin
            state         <= ST_IDLE;
            x             <= '0;
            m             <= RW'(1);
            k             <= '0;
            a             <= '0;
            b             <= '0;
            t             <= '0;
            r             <= '0;
            last          <= 1'b0;
            cand          <= '0;
            hop_cnt       <= '0;
            cause         <= KF_ERR_NONE;
            mod_go        <= 1'b0;
            m_route_valid <= 1'b0;
            m_route_id    <= '0;
            m_route_err   <= 1'b0;
            m_route_hops  <= '0;
        end else begin
            mod_go <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        k       <= s_hop_key;
                        r       <= kf_port_res(s_hop_port);
                        last    <= s_hop_last;
                        hop_cnt <= hop_inc;
                        if (hc != KF_ERR_NONE) begin
                            cause <= hc;
                            state <= s_hop_last ? ST_OUT : ST_DRAIN;
                        end else begin
                            state  <= ST_MOD_X;
                            mod_go <= 1'b1;
                        end
                    end
                end
                ST_MOD_X: begin
                    if (mod_done) begin
                        a      <= mod_rem;
                        state  <= ST_MOD_M;
                        mod_go <= 1'b1;
                    end
                end
                ST_MOD_M: begin
                    if (mod_done) begin
                        b     <= mod_rem;
                        t     <= '0;
                        cand  <= PW'(x);
                        state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (a == DW'(r)) begin
                        state <= ST_UPDATE;
                    end else if (t == k - DW'(1)) begin
                        cause <= KF_ERR_COPRIME;
                        state <= last ? ST_OUT : ST_DRAIN;
                    end else begin
                        t    <= t + DW'(1);
                        cand <= cand + PW'(m);
                        a    <= sum_red;
                    end
                end
                ST_UPDATE: begin
                    if (prod[PW-1:RW] != '0) begin
                        cause <= KF_ERR_OVF;
                        state <= last ? ST_OUT : ST_DRAIN;
                    end else begin
                        x     <= cand[RW-1:0];
                        m     <= prod[RW-1:0];
                        state <= last ? ST_OUT : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        hop_cnt <= hop_inc;
                        if (s_hop_last)
                            state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // Result registers load on the first OUT cycle.
                    if (!m_route_valid) begin
                        m_route_valid <= 1'b1;
                        m_route_id    <= (cause != KF_ERR_NONE) ? '0 : x;
                        m_route_err   <= cause != KF_ERR_NONE;
                        m_route_hops  <= hop_cnt;
                    end else if (m_route_ready) begin
                        m_route_valid <= 1'b0;
                        m_route_id    <= '0;
                        m_route_err   <= 1'b0;
                        m_route_hops  <= '0;
                        x             <= '0;
                        m             <= RW'(1);
                        hop_cnt       <= '0;
                        cause         <= KF_ERR_NONE;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keyflow_route_encoder.sv
// Scoreboard bench for keyflow_route_encoder: a 64-bit and a 16-bit
// label instance, directed and random routes against a CRT model.
module tb_keyflow_route_encoder;

    typedef struct {
        logic [63:0] id;
        bit          err;
        int          hops;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       hv;
    logic [1:0][15:0] hk;
    logic [1:0][2:0]  hp;
    logic [1:0]       hl;
    logic [1:0]       hr;
    logic [1:0]       rv;
    logic [1:0]       rr;
    logic [1:0]       re;
    logic [1:0][3:0]  rh;
    logic [63:0]      id0;
    logic [15:0]      id1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    int   total = 0;
    int   bad = 0;
    bit   bp_hold = 0;

    int unsigned ks[16];
    int unsigned ps[16];
    int unsigned primes[18] = '{2, 3, 5, 7, 11, 13, 17, 19, 23,
                                29, 31, 37, 41, 43, 47, 53, 59, 61};

    always #5 clk = ~clk;

    keyflow_route_encoder u_dut0 (
        .asclk        (clk),
        .reset        (reset),
        .s_hop_valid  (hv[0]),
        .s_hop_ready  (hr[0]),
        .s_hop_key    (hk[0]),
        .s_hop_port   (hp[0]),
        .s_hop_last   (hl[0]),
        .m_route_valid(rv[0]),
        .m_route_ready(rr[0]),
        .m_route_id   (id0),
        .m_route_err  (re[0]),
        .m_route_hops (rh[0])
    );

    keyflow_route_encoder #(
        .DIVIDER_WIDTH(16),
        .ROUTE_WIDTH  (16),
        .MAX_HOPS     (8)
    ) u_dut1 (
        .asclk        (clk),
        .reset        (reset),
        .s_hop_valid  (hv[1]),
        .s_hop_ready  (hr[1]),
        .s_hop_key    (hk[1]),
        .s_hop_port   (hp[1]),
        .s_hop_last   (hl[1]),
        .m_route_valid(rv[1]),
        .m_route_ready(rr[1]),
        .m_route_id   (id1),
        .m_route_err  (re[1]),
        .m_route_hops (rh[1])
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] id, input bit err,
                                input int hops);
        exp_t e;
        e.id = id;
        e.err = err;
        e.hops = hops;
        return e;
    endfunction

    // Reference: find the smallest x' = x + t*M with x' mod k = port+1.
    function automatic exp_t model(input int n, input int unsigned kk[16],
                                   input int unsigned pp[16], input int rw);
        logic [127:0] x, m, xn;
        bit err, found;
        exp_t e;
        x = 0;
        m = 1;
        xn = 0;
        err = 0;
        for (int i = 0; i < n; i++) begin
            if (!err) begin
                if (pp[i] > 4 || kk[i] < 2 || pp[i] + 1 >= kk[i] || i >= 8)
                    err = 1;
                else begin
                    found = 0;
                    for (int tt = 0; tt < int'(kk[i]) && !found; tt++)
                        if ((x + 128'(tt) * m) % 128'(kk[i]) == 128'(pp[i] + 1)) begin
                            xn = x + 128'(tt) * m;
                            found = 1;
                        end
                    if (!found)
                        err = 1;
                    else if (m * 128'(kk[i]) >= (128'd1 << rw))
                        err = 1;
                    else begin
                        x = xn;
                        m = m * 128'(kk[i]);
                    end
                end
            end
        end
        e.id = err ? 64'd0 : x[63:0];
        e.err = err;
        e.hops = (n > 15) ? 15 : n;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && rv[0] && rr[0]) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_route0: got id %0d want none", id0);
            end else begin
                e0 = q0.pop_front();
                chk("id0", id0, e0.id);
                chk("err0", 64'(re[0]), 64'(e0.err));
                chk("hops0", 64'(rh[0]), 64'(e0.hops));
            end
        end
        if (!reset && rv[1] && rr[1]) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_route1: got id %0d want none", id1);
            end else begin
                e1 = q1.pop_front();
                chk("id1", 64'(id1), e1.id);
                chk("err1", 64'(re[1]), 64'(e1.err));
                chk("hops1", 64'(rh[1]), 64'(e1.hops));
            end
        end
    end

    initial begin
        rr = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            rr[0] = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            rr[1] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_hop(input int d, input logic [15:0] k,
                            input logic [2:0] p, input logic l);
        int n;
        bit acc;
        n = 0;
        hv[d] = 1'b1;
        hk[d] = k;
        hp[d] = p;
        hl[d] = l;
        do begin
            @(negedge clk);
            acc = hr[d];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 3000);
        hv[d] = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL hop_accept_timeout%0d: got %0d cycles want accept", d, n);
        end
    endtask

    task automatic run_route(input int d, input int n, input exp_t e);
        if (d == 0)
            q0.push_back(e);
        else
            q1.push_back(e);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_hop(d, 16'(ks[i]), 3'(ps[i]), i == n - 1);
        end
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0",
                     q0.size() + q1.size());
        end
    endtask

    initial begin
        int n;
        int d;
        exp_t e;
        hv = '0;
        hk = '0;
        hp = '0;
        hl = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(hr[0]), 64'd0);
        chk("rst_valid", 64'(rv[0]), 64'd0);
        chk("rst_id", id0, 64'd0);
        chk("rst_err", 64'(re[0]), 64'd0);
        chk("rst_hops", 64'(rh[0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(hr[0]), 64'd1);
        chk("post_rst_valid", 64'(rv[0]), 64'd0);
        @(posedge clk);
        #1;

        ks[0] = 5;  ps[0] = 3;
        run_route(0, 1, mk(64'd4, 0, 1));
        ks[0] = 7;  ps[0] = 0;
        ks[1] = 11; ps[1] = 2;
        ks[2] = 13; ps[2] = 4;
        run_route(0, 3, mk(64'd421, 0, 3));
        ks[0] = 6;  ps[0] = 0;
        ks[1] = 9;  ps[1] = 1;
        run_route(0, 2, mk(64'd0, 1, 2));
        ks[0] = 7;  ps[0] = 6;
        ks[1] = 11; ps[1] = 0;
        ks[2] = 13; ps[2] = 1;
        run_route(0, 3, mk(64'd0, 1, 3));
        ks[0] = 5;  ps[0] = 3;
        run_route(0, 1, mk(64'd4, 0, 1));

        ks[0] = 251; ps[0] = 0;
        ks[1] = 257; ps[1] = 1;
        ks[2] = 7;   ps[2] = 2;
        run_route(1, 3, mk(64'd0, 1, 3));
        run_route(1, 2, mk(64'd53715, 0, 2));
        drain_wait();

        bp_hold = 1;
        ks[0] = 5; ps[0] = 3;
        run_route(0, 1, mk(64'd4, 0, 1));
        n = 0;
        while (rv[0] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid", 64'(rv[0]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_id", id0, 64'd4);
            chk("hold_err", 64'(re[0]), 64'd0);
            chk("hold_hops", 64'(rh[0]), 64'd1);
            chk("hold_ready", 64'(hr[0]), 64'd0);
        end
        bp_hold = 0;
        @(posedge clk);
        #1;
        drain_wait();

        send_hop(0, 16'd61, 3'd4, 1'b1);
        repeat (133) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'(hr[0]), 64'd0);
        chk("abort_valid", 64'(rv[0]), 64'd0);
        chk("abort_id", id0, 64'd0);
        chk("abort_hops", 64'(rh[0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 64'(hr[0]), 64'd1);
        @(posedge clk);
        #1;
        ks[0] = 5; ps[0] = 3;
        run_route(0, 1, mk(64'd4, 0, 1));

        for (int r = 0; r < 28; r++) begin
            d = (r % 4 == 3) ? 1 : 0;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                ks[i] = primes[$urandom_range(0, 17)];
                if ($urandom_range(0, 19) == 0)
                    ks[i] = $urandom_range(0, 1);
                if ($urandom_range(0, 15) == 0)
                    ps[i] = $urandom_range(5, 7);
                else
                    ps[i] = $urandom_range(0, 4);
            end
            e = model(n, ks, ps, (d == 1) ? 16 : 64);
            run_route(d, n, e);
        end
        drain_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
